// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding and default width.
package serial_sub_pkg;

   localparam int DEF_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

endpackage

// File: rtl/serial_sub_fa_bit.sv
// Combinational 1-bit full adder; the single arithmetic cell of the serial datapath.
module fa_bit (
   input  logic x,
   input  logic y,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = x ^ y ^ ci;
   assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor: diff = a - b - bin, LSB first, one bit per clock through one
// full-adder cell, with a start/busy/done handshake and registered result flags.
module serial_sub
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf,
   output logic             zero
);

   localparam int CW = $clog2(WIDTH);

   state_t           state, nxt;
   logic [WIDTH-1:0] a_sh, b_sh;
   logic [WIDTH-2:0] res;
   logic [WIDTH-1:0] res_nxt;
   logic [CW-1:0]    cnt;
   logic             c, a_msb, b_msb;
   logic             s, co, accept, last;

   assign accept  = start && (state != RUN);
   assign last    = (state == RUN) && (cnt == CW'(WIDTH-1));
   assign res_nxt = {s, res};
   assign busy    = (state == RUN);
   assign done    = (state == DONE);

   // subtraction as a + ~b + ~bin; carry register holds the inverted borrow
   fa_bit u_fa (
      .x  (a_sh[0]),
      .y  (~b_sh[0]),
      .ci (c),
      .s  (s),
      .co (co)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (start) nxt = RUN;
         RUN:     if (last)  nxt = DONE;
         DONE:    nxt = start ? RUN : IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh  <= '0;
         b_sh  <= '0;
         res   <= '0;
         cnt   <= '0;
         c     <= 1'b0;
         a_msb <= 1'b0;
         b_msb <= 1'b0;
         diff  <= '0;
         bout  <= 1'b0;
         ovf   <= 1'b0;
         zero  <= 1'b0;
      end else if (accept) begin
         a_sh  <= a;
         b_sh  <= b;
         res   <= '0;
         cnt   <= '0;
         c     <= ~bin;
         a_msb <= a[WIDTH-1];
         b_msb <= b[WIDTH-1];
      end else if (state == RUN) begin
         a_sh <= a_sh >> 1;
         b_sh <= b_sh >> 1;
         res  <= res_nxt[WIDTH-1:1];
         cnt  <= cnt + 1'b1;
         c    <= co;
         // visible outputs change only on the completion edge
         if (last) begin
            diff <= res_nxt;
            bout <= ~co;
            ovf  <= (a_msb ^ b_msb) & (s ^ a_msb);
            zero <= (res_nxt == '0);
         end
      end
   end

endmodule

// File: tb/tb_serial_sub.sv
// Randomized plus directed bench for serial_sub (WIDTH=4) against an arithmetic model.
module tb_serial_sub;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a = '0, b = '0;
   logic         bin = 1'b0;
   logic         busy, done, bout, ovf, zero;
   logic [W-1:0] diff;

   int n_chk = 0;
   int n_fail = 0;

   logic [W-1:0] p_d;
   logic         p_bout, p_ovf, p_zero;

   serial_sub #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
      .busy(busy), .done(done), .diff(diff), .bout(bout), .ovf(ovf), .zero(zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_hold(input string tag);
      chk({tag, ".diff"}, 32'(diff), 32'(p_d));
      chk({tag, ".bout"}, 32'(bout), 32'(p_bout));
      chk({tag, ".ovf"},  32'(ovf),  32'(p_ovf));
      chk({tag, ".zero"}, 32'(zero), 32'(p_zero));
   endtask

   task automatic idle_chk();
      @(posedge clk); @(negedge clk);
      chk("idle.done", 32'(done), 0);
      chk("idle.busy", 32'(busy), 0);
      chk_hold("idle");
   endtask

   // called at a negedge; drives start there so it is accepted on the next posedge
   task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                         input bit inject);
      int           dv;
      logic [W-1:0] e_d;
      logic         e_bout, e_ovf;
      dv     = int'(ia) - int'(ib) - int'(ibin);
      e_d    = dv[W-1:0];
      e_bout = int'(ia) < int'(ib) + int'(ibin);
      e_ovf  = (ia[W-1] != ib[W-1]) && (e_d[W-1] != ia[W-1]);
      a = ia; b = ib; bin = ibin; start = 1'b1;
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      chk("acc.busy", 32'(busy), 1);
      chk("acc.done", 32'(done), 0);
      chk_hold("acc");
      for (int i = 1; i <= W; i++) begin
         @(posedge clk); @(negedge clk);
         if (i < W) begin
            chk("run.done", 32'(done), 0);
            chk("run.busy", 32'(busy), 1);
            chk_hold("run");
         end else begin
            chk("fin.done", 32'(done), 1);
            chk("fin.busy", 32'(busy), 0);
            chk("fin.diff", 32'(diff), 32'(e_d));
            chk("fin.bout", 32'(bout), 32'(e_bout));
            chk("fin.ovf",  32'(ovf),  32'(e_ovf));
            chk("fin.zero", 32'(zero), 32'(e_d == '0));
            p_d = e_d; p_bout = e_bout; p_ovf = e_ovf; p_zero = (e_d == '0);
         end
         if (inject && i == 2) begin
            start = 1'b1; a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
         end
         if (inject && i == 3) start = 1'b0;
      end
   endtask

   initial begin
      p_d = '0; p_bout = 1'b0; p_ovf = 1'b0; p_zero = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst.busy", 32'(busy), 0);
      chk("rst.done", 32'(done), 0);
      chk_hold("rst");
      rst_n = 1'b1;
      @(negedge clk);

      run_op(4'd9, 4'd3, 1'b0, 1'b0);
      idle_chk();
      run_op(4'd3, 4'd9, 1'b0, 1'b0);
      idle_chk();
      run_op(4'd5, 4'd5, 1'b0, 1'b0);
      idle_chk();
      run_op(4'd0, 4'd0, 1'b1, 1'b0);
      idle_chk();
      run_op(4'd9, 4'd3, 1'b0, 1'b1);
      idle_chk();
      run_op(4'd6, 4'd2, 1'b1, 1'b0);
      run_op(4'd8, 4'd1, 1'b0, 1'b0);   // back-to-back from DONE
      idle_chk();

      // reset two cycles into RUN
      a = 4'd7; b = 4'd2; bin = 1'b0; start = 1'b1;
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      repeat (2) begin @(posedge clk); @(negedge clk); end
      rst_n = 1'b0;
      #1;
      p_d = '0; p_bout = 1'b0; p_ovf = 1'b0; p_zero = 1'b0;
      chk("mrst.busy", 32'(busy), 0);
      chk("mrst.done", 32'(done), 0);
      chk_hold("mrst");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (W + 2) idle_chk();
      run_op(4'd12, 4'd4, 1'b1, 1'b0);

      for (int k = 0; k < 40; k++) begin
         if ($urandom_range(0, 1) == 1) idle_chk();
         run_op(W'($urandom), W'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));
      end
      idle_chk();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
